// File: rtl/mem_access_stage_if.sv
// Data-memory port of the memory-access stage.
// Request/grant/response protocol with variable latency.
//   master (stage)  : drives dm_req, dm_we, dm_addr, dm_wdata, dm_be
//   slave  (memory) : drives dm_gnt, dm_rvalid, dm_rdata
interface mem_access_stage_if;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      input  dm_gnt, dm_rvalid, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      output dm_gnt, dm_rvalid, dm_rdata
   );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage of the RISC-V pipeline, between E/M and M/W.
// Turns load/store instructions into requests on the data-memory port,
// stalls upstream while a transfer is in flight, aborts with a bus error
// after TIMEOUT wait cycles, and forwards control fields to M/W.
// Ports:
//   clk, rst                 clock, async active-low reset
//   in_valid .. ecall_sig    instruction fields from E/M
//   stall, out_valid         pipeline control
//   dm_out                   load word shifted right by the byte offset
//   *_o                      forwarded fields (wb_en_o killed on errors)
//   misaligned, bus_err      one-cycle error pulses
//   dm                       data-memory port (master side)
//
// state | meaning
// IDLE  | accepting an instruction; non-memory/misaligned ops finish here
// REQ   | dm_req high, waiting for dm_gnt
// RESP  | load granted, waiting for dm_rvalid
// DONE  | transfer finished (or aborted), out_valid high for one cycle
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  func3,
   input  logic [31:0] alu_out,
   input  logic [31:0] rs2_data,
   input  logic [4:0]  rd_index,
   input  logic        wb_en,
   input  logic        wb_sel,
   input  logic        ecall_sig,
   output logic        stall,
   output logic        out_valid,
   output logic [31:0] dm_out,
   output logic [31:0] alu_out_o,
   output logic [4:0]  rd_index_o,
   output logic [2:0]  func3_o,
   output logic        wb_en_o,
   output logic        wb_sel_o,
   output logic        ecall_sig_o,
   output logic        misaligned,
   output logic        bus_err,
   mem_access_stage_if.master dm
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
   logic          err_q, err_nxt;
   logic [31:0]   ld_q, ld_nxt;

   logic [1:0]    off;
   logic          is_mem, mis_c, mem_ok;
   logic [3:0]    be_c;
   logic [31:0]   wd_c;

   assign off     = alu_out[1:0];
   assign is_mem  = in_valid & (is_load | is_store);
   // H/HU need even addresses, W needs word alignment
   assign mis_c   = ((func3[1:0] == 2'b01) & off[0]) |
                    ((func3[1:0] == 2'b10) & (off != 2'b00));
   assign mem_ok  = is_mem & ~mis_c;
   assign cnt_inc = cnt + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         err_q <= 1'b0;
         ld_q  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         err_q <= err_nxt;
         ld_q  <= ld_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = err_q;
      ld_nxt    = ld_q;
      unique case (state)
         IDLE: begin
            err_nxt = 1'b0;
            if (mem_ok) begin
               state_nxt = REQ;
               cnt_nxt   = '0;
            end
         end
         REQ: begin
            if (dm.dm_gnt) begin
               state_nxt = is_store ? DONE : RESP;
               cnt_nxt   = '0;
            end else if (cnt_inc == CW'(TIMEOUT)) begin
               state_nxt = DONE;
               err_nxt   = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         RESP: begin
            if (dm.dm_rvalid) begin
               state_nxt = DONE;
               ld_nxt    = dm.dm_rdata >> {off, 3'b000};
            end else if (cnt_inc == CW'(TIMEOUT)) begin
               state_nxt = DONE;
               err_nxt   = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            err_nxt   = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // store lane replication and byte enables; loads request no lanes
   always_comb begin
      be_c = 4'b0000;
      wd_c = '0;
      if (is_store) begin
         unique case (func3[1:0])
            2'b00: begin
               wd_c = {4{rs2_data[7:0]}};
               be_c = 4'b0001 << off;
            end
            2'b01: begin
               wd_c = {2{rs2_data[15:0]}};
               be_c = 4'b0011 << off;
            end
            default: begin
               wd_c = rs2_data;
               be_c = 4'b1111;
            end
         endcase
      end
   end

   // every output is forced low while reset is held, pass-throughs included
   assign stall       = rst & ((state == REQ) | (state == RESP) |
                               ((state == IDLE) & mem_ok));
   assign out_valid   = rst & ((state == DONE) |
                               ((state == IDLE) & in_valid & ~mem_ok));
   assign misaligned  = rst & (state == IDLE) & is_mem & mis_c;
   assign bus_err     = rst & (state == DONE) & err_q;
   assign wb_en_o     = rst & wb_en & ~misaligned & ~bus_err;
   assign dm_out      = (rst & ~(in_valid & is_store)) ? ld_q : '0;
   assign alu_out_o   = rst ? alu_out : '0;
   assign rd_index_o  = rst ? rd_index : '0;
   assign func3_o     = rst ? func3 : '0;
   assign wb_sel_o    = rst & wb_sel;
   assign ecall_sig_o = rst & ecall_sig;

   assign dm.dm_req   = rst & (state == REQ);
   assign dm.dm_we    = rst & (state == REQ) & is_store;
   assign dm.dm_addr  = rst ? {alu_out[31:2], 2'b00} : '0;
   assign dm.dm_wdata = rst ? wd_c : '0;
   assign dm.dm_be    = rst ? be_c : '0;
endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid, is_load, is_store;
   logic [2:0]  func3;
   logic [31:0] alu_out, rs2_data;
   logic [4:0]  rd_index;
   logic        wb_en, wb_sel, ecall_sig;
   logic        stall, out_valid, wb_en_o, wb_sel_o, ecall_sig_o, misaligned, bus_err;
   logic [31:0] dm_out, alu_out_o;
   logic [4:0]  rd_index_o;
   logic [2:0]  func3_o;

   mem_access_stage_if dm();

   mem_access_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .is_load(is_load), .is_store(is_store),
      .func3(func3), .alu_out(alu_out), .rs2_data(rs2_data), .rd_index(rd_index),
      .wb_en(wb_en), .wb_sel(wb_sel), .ecall_sig(ecall_sig), .stall(stall),
      .out_valid(out_valid), .dm_out(dm_out), .alu_out_o(alu_out_o),
      .rd_index_o(rd_index_o), .func3_o(func3_o), .wb_en_o(wb_en_o), .wb_sel_o(wb_sel_o),
      .ecall_sig_o(ecall_sig_o), .misaligned(misaligned), .bus_err(bus_err), .dm(dm)
   );

   always #5 clk = ~clk;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   // reference memory image and last successfully loaded (shifted) word
   logic [31:0] mem [int unsigned];
   logic [31:0] last_ld = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [29:0] w);
      if (mem.exists(w)) return mem[w];
      return {2'b00, w} ^ 32'h5A5A_0000;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
         dm.dm_gnt = 1'b0; dm.dm_rvalid = 1'b0;
      end
   endtask

   // Issue one instruction; memory grants after g REQ cycles and answers
   // after r RESP cycles (>= TO means never). Returns at the out_valid cycle.
   task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input int g, input int r);
      int          sz, exp_cyc, cyc, reqn, respn, stalln;
      bit          mem_op, mis, err, got, req_seen;
      logic [1:0]  off;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd, word;
      logic [4:0]  rdi;
      logic        wbe;
      cyc = 0; reqn = 0; respn = 0; stalln = 0; got = 0; req_seen = 0;
      rdi = 5'($urandom); wbe = 1'($urandom);
      off = a[1:0];
      mem_op = ld | st;
      sz = 1 << f3[1:0];
      mis = mem_op && ((a % sz) != 0);
      exp_be = '0; exp_wd = '0;
      if (st) begin
         for (int b = 0; b < 4; b++) begin
            exp_wd[8*b +: 8] = d[8*(b % sz) +: 8];
            if (b >= off && b < off + sz) exp_be[b] = 1'b1;
         end
      end
      err = 0; exp_cyc = 1;
      if (mem_op && !mis) begin
         if (g >= TO) begin exp_cyc = TO + 2; err = 1; end
         else if (st) exp_cyc = g + 3;
         else if (r >= TO) begin exp_cyc = g + TO + 3; err = 1; end
         else exp_cyc = g + r + 4;
      end

      @(posedge clk); #1;
      in_valid = 1'b1; is_load = ld; is_store = st; func3 = f3; alu_out = a;
      rs2_data = d; rd_index = rdi; wb_en = wbe; wb_sel = 1'($urandom); ecall_sig = 1'($urandom);
      dm.dm_gnt = 1'b0; dm.dm_rvalid = 1'b0;
      while (!got && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (stall) stalln++;
         if (dm.dm_req) begin
            if (!req_seen) begin
               chk("dm_addr", dm.dm_addr, {a[31:2], 2'b00});
               chk("dm_be", {28'b0, dm.dm_be}, {28'b0, exp_be});
               chk("dm_we", {31'b0, dm.dm_we}, {31'b0, st});
               if (st) chk("dm_wdata", dm.dm_wdata, exp_wd);
            end
            req_seen = 1;
            dm.dm_gnt = (reqn == g);
            dm.dm_rvalid = !dm.dm_gnt && ($urandom_range(0, 3) == 0);
            dm.dm_rdata = $urandom;
            reqn++;
         end else if (stall && req_seen) begin
            dm.dm_gnt = 1'b0;
            dm.dm_rvalid = (respn == r);
            dm.dm_rdata = (respn == r) ? mem_rd(a[31:2]) : $urandom;
            respn++;
         end else begin
            dm.dm_gnt = 1'b0; dm.dm_rvalid = 1'b0;
         end
         if (out_valid) got = 1;
         else begin @(posedge clk); #1; end
      end
      chk("done_seen", {31'b0, got}, 32'd1);
      chk("cycles", cyc, exp_cyc);
      chk("stall_cycles", stalln, exp_cyc - 1);
      chk("stall_at_done", {31'b0, stall}, 32'd0);
      chk("req_seen", {31'b0, req_seen}, {31'b0, mem_op && !mis});
      chk("misaligned", {31'b0, misaligned}, {31'b0, mis});
      chk("bus_err", {31'b0, bus_err}, {31'b0, err});
      chk("wb_en_o", {31'b0, wb_en_o}, {31'b0, wbe && !mis && !err});
      chk("alu_out_o", alu_out_o, a);
      chk("rd_index_o", {27'b0, rd_index_o}, {27'b0, rdi});
      chk("func3_o", {29'b0, func3_o}, {29'b0, f3});
      if (ld && !mis && !err) last_ld = mem_rd(a[31:2]) >> {off, 3'b000};
      if (ld) chk("dm_out", dm_out, last_ld);
      else if (st) chk("dm_out_store", dm_out, 32'd0);
      if (st && !mis && !err) begin
         word = mem_rd(a[31:2]);
         for (int b = 0; b < 4; b++) if (exp_be[b]) word[8*b +: 8] = exp_wd[8*b +: 8];
         mem[a[31:2]] = word;
      end
   endtask

   initial begin
      logic [2:0] ld_f3 [5];
      ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
      ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
      dm.dm_gnt = 1'b0; dm.dm_rvalid = 1'b0; dm.dm_rdata = '0;
      // inputs active during reset: every output must stay low
      in_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; func3 = 3'b010;
      alu_out = 32'h0000_0100; rs2_data = 32'hCAFE_F00D; rd_index = 5'd7;
      wb_en = 1'b1; wb_sel = 1'b1; ecall_sig = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_dm_req", {31'b0, dm.dm_req}, 32'd0);
      chk("rst_dm_wdata", dm.dm_wdata, 32'd0);
      chk("rst_dm_be", {28'b0, dm.dm_be}, 32'd0);
      chk("rst_alu_out_o", alu_out_o, 32'd0);
      chk("rst_wb_en_o", {31'b0, wb_en_o}, 32'd0);
      in_valid = 1'b0; is_store = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("post_rst_dm_out", dm_out, 32'd0);

      // directed cases
      run_op(0, 0, 3'b000, 32'h0000_1234, 32'h0, 0, 0);
      mem[32'h100 >> 2] = 32'hAABB_CCDD;
      idle(1);
      run_op(1, 0, 3'b000, 32'h0000_0103, 32'h0, 0, 0);
      idle(1);
      run_op(0, 1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 2, 0);
      idle(1);
      run_op(1, 0, 3'b010, 32'h0000_0101, 32'h0, 0, 0);
      idle(1);
      run_op(1, 0, 3'b010, 32'h0000_0100, 32'h0, TO, 0);
      dm.dm_rvalid = 1'b1; dm.dm_rdata = 32'h1357_9BDF;
      idle(1);
      dm.dm_rvalid = 1'b1;
      @(negedge clk);
      chk("late_rvalid_ignored", dm_out, last_ld);
      dm.dm_rvalid = 1'b0;
      run_op(1, 0, 3'b101, 32'h0000_0202, 32'h0, 1, TO);
      run_op(0, 1, 3'b010, 32'h0000_0200, 32'h1122_3344, 15, 0);
      run_op(1, 0, 3'b010, 32'h0000_0200, 32'h0, 0, 15);

      // reset asserted while waiting for the response
      @(posedge clk); #1;
      in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; func3 = 3'b010;
      alu_out = 32'h0000_0100; wb_en = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk); dm.dm_gnt = 1'b1;
      @(posedge clk); #1; dm.dm_gnt = 1'b0;
      chk("resp_stall", {31'b0, stall}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_dm_req", {31'b0, dm.dm_req}, 32'd0);
      chk("midrst_stall", {31'b0, stall}, 32'd0);
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      in_valid = 1'b0; is_load = 1'b0;
      @(negedge clk); rst = 1'b1; last_ld = '0;
      @(negedge clk);
      chk("after_rst_dm_out", dm_out, 32'd0);
      chk("after_rst_stall", {31'b0, stall}, 32'd0);
      run_op(0, 0, 3'b011, 32'h0000_00FC, 32'h0, 0, 0);

      // randomized traffic, sometimes back-to-back
      for (int i = 0; i < 60; i++) begin
         int          kind, g, r;
         logic [2:0]  f3;
         logic [31:0] a;
         kind = $urandom_range(0, 4);
         a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
         g = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
         r = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
         if (kind == 0) run_op(0, 0, 3'($urandom), $urandom, $urandom, 0, 0);
         else if (kind <= 2) begin
            f3 = ld_f3[$urandom_range(0, 4)];
            run_op(1, 0, f3, a, 32'h0, g, r);
         end else begin
            f3 = 3'($urandom_range(0, 2));
            run_op(0, 1, f3, a, $urandom, g, 0);
         end
         if ($urandom_range(0, 1) == 0) idle(1);
      end
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
